// File: rtl/aec_result_ascii_if.sv
// Result-in / ASCII-byte-out bundle for aec_result_ascii.
// master: the formatter (drives char_*, status); slave: the calculator/sink side.
interface aec_result_ascii_if;
  logic       valid;
  logic [6:0] result;
  logic [7:0] char_out;
  logic       char_valid;
  logic       char_ready;
  logic       char_last;
  logic       fifo_full;
  logic       drop_err;

  modport master (
    input  valid, result, char_ready,
    output char_out, char_valid, char_last,
    output fifo_full, drop_err
  );

  modport slave (
    output valid, result, char_ready,
    input  char_out, char_valid, char_last,
    input  fifo_full, drop_err
  );
endinterface

// File: rtl/aec_result_ascii.sv
// Buffers 7-bit calculator results in a FIFO and streams each one as decimal
// ASCII (optional terminator) on a valid/ready byte port. Ports: clk, rst, io.
module aec_result_ascii #(
  parameter int          DEPTH     = 4,
  parameter logic [7:0]  TERM      = 8'h0A,
  parameter bit          SEND_TERM = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  aec_result_ascii_if.master  io
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE, LOAD, SEND_H, SEND_T, SEND_O, SEND_TRM
  } state_t;

  state_t        state;
  logic [6:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          full, pop, push;

  logic [6:0]    head, rem, lo;
  logic          hun;
  logic [3:0]    ten, one;
  logic [3:0]    t_q, o_q;

  logic [7:0]    out_q;
  logic          vld_q, last_q, drop_q;

  function automatic logic [7:0] asc(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  assign full = (count == (AW+1)'(DEPTH));
  assign pop  = (state == LOAD);
  // full is judged before the same-cycle pop
  assign push = io.valid && (!full || pop);

  // r <= 127: hundreds is 0 or 1, tens by compare ladder
  always_comb begin
    head = mem[rptr];
    hun  = (head >= 7'd100);
    rem  = hun ? head - 7'd100 : head;
    ten  = 4'd0;
    for (int i = 1; i <= 9; i++) begin
      if (rem >= 7'(10 * i)) ten = 4'(i);
    end
    lo  = rem - 7'(10 * ten);
    one = lo[3:0];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= io.result;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      drop_q <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (io.valid && !push) drop_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      t_q    <= '0;
      o_q    <= '0;
      out_q  <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (count != '0) state <= LOAD;
        end
        LOAD: begin
          t_q   <= ten;
          o_q   <= one;
          vld_q <= 1'b1;
          if (hun) begin
            state  <= SEND_H;
            out_q  <= 8'h31;
            last_q <= 1'b0;
          end else if (ten != 4'd0) begin
            state  <= SEND_T;
            out_q  <= asc(ten);
            last_q <= 1'b0;
          end else begin
            state  <= SEND_O;
            out_q  <= asc(one);
            last_q <= !SEND_TERM;
          end
        end
        SEND_H: begin
          if (io.char_ready) begin
            state <= SEND_T;
            out_q <= asc(t_q);
          end
        end
        SEND_T: begin
          if (io.char_ready) begin
            state  <= SEND_O;
            out_q  <= asc(o_q);
            last_q <= !SEND_TERM;
          end
        end
        SEND_O: begin
          if (io.char_ready) begin
            if (SEND_TERM) begin
              state  <= SEND_TRM;
              out_q  <= TERM;
              last_q <= 1'b1;
            end else begin
              state  <= IDLE;
              out_q  <= '0;
              vld_q  <= 1'b0;
              last_q <= 1'b0;
            end
          end
        end
        SEND_TRM: begin
          if (io.char_ready) begin
            state  <= IDLE;
            out_q  <= '0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          vld_q  <= 1'b0;
          last_q <= 1'b0;
        end
      endcase
    end
  end

  assign io.char_out   = out_q;
  assign io.char_valid = vld_q;
  assign io.char_last  = last_q;
  assign io.fifo_full  = full;
  assign io.drop_err   = drop_q;
endmodule
